flag_bit_serializer: RTL

// - Accepts one WIDTH-bit flag word per handshake. Scans it LSB->MSB at one bit per clock.
// - Emits the index of every set bit, in ascending order, on a valid/ready stream.
// - Sits downstream of the flag producers and feeds the index consumer (event dispatcher).
// - Hardware form of the "find a TRUE bit" loop, extended to serve every set bit, not only the first.

---
 rtl/flag_bit_serializer.sv | 111 +++++++++++
 1 files changed

// File: rtl/flag_bit_serializer.sv
// Scans an accepted flag word LSB->MSB and streams the index of every set bit.
// Define FLAG_SER_FIRST_ONLY_EN to emit only the lowest set bit of each word.
module flag_bit_serializer #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             zero_word
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_r, idx_nxt;
    logic             last_r, last_nxt;
    logic             zero_r, zero_nxt;
    logic [WIDTH-1:0] bit_mask;

    assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            ptr    <= '0;
            idx_r  <= '0;
            last_r <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            ptr    <= ptr_nxt;
            idx_r  <= idx_nxt;
            last_r <= last_nxt;
            zero_r <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        ptr_nxt    = ptr;
        idx_nxt    = idx_r;
        last_nxt   = last_r;
        zero_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_flag == '0) begin
                        zero_nxt = 1'b1;
                    end else begin
                        shadow_nxt = in_flag;
                        ptr_nxt    = '0;
                        state_nxt  = SCAN;
                    end
                end
            end
            SCAN: begin
                // A set bit always lies at or above ptr here, so ptr cannot run off the top.
                if ((shadow & bit_mask) != '0) begin
                    idx_nxt   = ptr;
`ifdef FLAG_SER_FIRST_ONLY_EN
                    last_nxt  = 1'b1;
`else
                    last_nxt  = ((shadow & ~bit_mask) == '0);
`endif
                    state_nxt = EMIT;
                end else begin
                    ptr_nxt = ptr + IDX_W'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
`ifdef FLAG_SER_FIRST_ONLY_EN
                    shadow_nxt = '0;
`else
                    shadow_nxt = shadow & ~bit_mask;
`endif
                    if (last_r) begin
                        state_nxt = IDLE;
                    end else begin
                        ptr_nxt   = ptr + IDX_W'(1);
                        state_nxt = SCAN;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_index = idx_r;
    assign out_last  = last_r;
    assign zero_word = zero_r;

endmodule
